oam_dma: RTL and testbench

Sprite-attribute DMA engine for the PPU's object attribute memory. A CPU write of page number P to the DMA register stalls the CPU and copies CPU bus bytes $P00–$PFF into the 256-byte OAM synchronous RAM, starting at the current OAM address offset and wrapping. It sits directly upstream of the OAM RAM, driving its write enable, address and write data, and alongside the CPU bus arbiter, which it controls through a ready/halt line.

---
 rtl/oam_dma.sv | 156 +++++++++++++++
 tb/tb_oam_dma.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA engine.
// A CPU write of page P to REG_ADDR halts the CPU and copies bus bytes
// {P,00}..{P,FF} into the OAM RAM, starting at the sampled OAM offset and
// wrapping. Each byte takes one READ cycle and one WRITE cycle.
// Build option: define OAM_DMA_ALIGN_EN to insert one ALIGN cycle after HALT
// when the free-running parity flop is 1 (odd-cycle DMA penalty).
module oam_dma #(
   parameter int          ADDR_WIDTH = 8,
   parameter int          DATA_WIDTH = 8,
   parameter logic [15:0] REG_ADDR   = 16'h4014
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_dout,
   input  logic                  cpu_wr,
   input  logic [ADDR_WIDTH-1:0] oam_start,
   input  logic [DATA_WIDTH-1:0] bus_din,
   output logic                  cpu_rdy,
   output logic                  dma_active,
   output logic                  dma_rd,
   output logic [15:0]           dma_addr,
   output logic                  oam_we,
   output logic [ADDR_WIDTH-1:0] oam_addr,
   output logic [DATA_WIDTH-1:0] oam_din
);

`ifdef OAM_DMA_ALIGN_EN
   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
   typedef enum logic [1:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

   state_t                  state_q;
   logic [DATA_WIDTH-1:0]   page_q;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic [ADDR_WIDTH-1:0]   cnt_d;
   logic                    trigger_d;
   logic                    last_d;

   logic                    cpu_rdy_q;
   logic                    dma_active_q;
   logic                    dma_rd_q;
   logic [15:0]             dma_addr_q;
   logic                    oam_we_q;
   logic [ADDR_WIDTH-1:0]   oam_addr_q;

   // Bus read address for a given page and byte index.
   function automatic logic [15:0] rd_addr(input logic [DATA_WIDTH-1:0] pg,
                                           input logic [ADDR_WIDTH-1:0] c);
      return 16'({pg, c});
   endfunction

   assign trigger_d = cpu_wr && (cpu_addr == REG_ADDR);
   assign cnt_d     = cnt_q + 1'b1;
   assign last_d    = (cnt_q == {ADDR_WIDTH{1'b1}});

`ifdef OAM_DMA_ALIGN_EN
   logic parity_q;

   // Free-running parity flop; tracks the CPU's even/odd cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_q <= 1'b0;
      else        parity_q <= ~parity_q;
   end
`endif

   // Transfer FSM; outputs are registered together with the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         page_q       <= '0;
         base_q       <= '0;
         cnt_q        <= '0;
         cpu_rdy_q    <= 1'b1;
         dma_active_q <= 1'b0;
         dma_rd_q     <= 1'b0;
         dma_addr_q   <= '0;
         oam_we_q     <= 1'b0;
         oam_addr_q   <= '0;
      end else begin
         // Strobes and addresses are only non-zero in their own state.
         dma_rd_q   <= 1'b0;
         dma_addr_q <= '0;
         oam_we_q   <= 1'b0;
         oam_addr_q <= '0;
         case (state_q)
            IDLE: begin
               if (trigger_d) begin
                  page_q       <= cpu_dout;
                  base_q       <= oam_start;
                  cnt_q        <= '0;
                  state_q      <= HALT;
                  cpu_rdy_q    <= 1'b0;
                  dma_active_q <= 1'b1;
               end
            end
            HALT: begin
`ifdef OAM_DMA_ALIGN_EN
               if (parity_q) begin
                  state_q <= ALIGN;
               end else begin
                  state_q    <= READ;
                  dma_rd_q   <= 1'b1;
                  dma_addr_q <= rd_addr(page_q, cnt_q);
               end
`else
               state_q    <= READ;
               dma_rd_q   <= 1'b1;
               dma_addr_q <= rd_addr(page_q, cnt_q);
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: begin
               state_q    <= READ;
               dma_rd_q   <= 1'b1;
               dma_addr_q <= rd_addr(page_q, cnt_q);
            end
`endif
            READ: begin
               state_q    <= WRITE;
               oam_we_q   <= 1'b1;
               oam_addr_q <= base_q + cnt_q;
            end
            WRITE: begin
               if (last_d) begin
                  state_q      <= IDLE;
                  cpu_rdy_q    <= 1'b1;
                  dma_active_q <= 1'b0;
               end else begin
                  cnt_q      <= cnt_d;
                  state_q    <= READ;
                  dma_rd_q   <= 1'b1;
                  dma_addr_q <= rd_addr(page_q, cnt_d);
               end
            end
            default: begin
               state_q      <= IDLE;
               cpu_rdy_q    <= 1'b1;
               dma_active_q <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_rdy    = cpu_rdy_q;
   assign dma_active = dma_active_q;
   assign dma_rd     = dma_rd_q;
   assign dma_addr   = dma_addr_q;
   assign oam_we     = oam_we_q;
   assign oam_addr   = oam_addr_q;
   // Read data from the previous READ cycle flows straight into the RAM.
   assign oam_din    = oam_we_q ? bus_din : '0;

endmodule

// File: tb/tb_oam_dma.sv
// Testbench for oam_dma: bus model, output monitor and scenario tasks.
module tb_oam_dma;

   localparam logic [15:0] REG = 16'h4014;
`ifdef OAM_DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_dout = '0;
   logic        cpu_wr = 1'b0;
   logic [7:0]  oam_start = '0;
   logic [7:0]  bus_din = '0;
   logic        cpu_rdy, dma_active, dma_rd, oam_we;
   logic [15:0] dma_addr;
   logic [7:0]  oam_addr, oam_din;

   int n_vec = 0;
   int n_err = 0;
   int bus_mode = 0;
   int halt_cnt = 0;
   int leak = 0;
   logic mpar;
   logic [15:0] rd_q[$];
   logic [15:0] wr_q[$];

   oam_dma dut (
      .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
      .cpu_wr(cpu_wr), .oam_start(oam_start), .bus_din(bus_din),
      .cpu_rdy(cpu_rdy), .dma_active(dma_active), .dma_rd(dma_rd),
      .dma_addr(dma_addr), .oam_we(oam_we), .oam_addr(oam_addr), .oam_din(oam_din)
   );

   always #5 clk = ~clk;

   // Memory contents seen on the CPU bus.
   function automatic logic [7:0] bus_fn(input logic [15:0] a);
      if (bus_mode == 0) return a[7:0];
      return a[7:0] ^ (a[15:8] * 8'd29) ^ 8'hA5;
   endfunction

   // Bus: data for the address presented in cycle N appears in cycle N+1.
   always @(posedge clk) bus_din <= bus_fn(dma_addr);

   // Parity reference: zero out of reset, flips every clock.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) mpar <= 1'b0;
      else        mpar <= ~mpar;

   // Monitor: log reads, writes and halted cycles; count idle-value leaks.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!cpu_rdy) halt_cnt++;
         if (dma_rd) rd_q.push_back(dma_addr);
         if (oam_we) wr_q.push_back({oam_addr, oam_din});
         if ((!dma_rd && dma_addr !== 16'h0) ||
             (!oam_we && (oam_addr !== 8'h0 || oam_din !== 8'h0)) ||
             (dma_active !== ~cpu_rdy) || (dma_rd && oam_we))
            leak++;
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({cpu_rdy, dma_active, dma_rd, oam_we, dma_addr, oam_addr, oam_din} !== {4'b1000, 32'h0}) begin
         n_err++;
         $display("FAIL reset_values got rdy=%b act=%b rd=%b we=%b da=%h oa=%h od=%h want 1 0 0 0 0 0 0",
                  cpu_rdy, dma_active, dma_rd, oam_we, dma_addr, oam_addr, oam_din);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_vec++;
         if ({cpu_rdy, dma_active, dma_rd, oam_we, dma_addr, oam_addr} !== {4'b1000, 24'h0}) begin
            n_err++;
            $display("FAIL idle_cycle%0d got rdy=%b act=%b rd=%b we=%b want rdy=1 others 0",
                     i, cpu_rdy, dma_active, dma_rd, oam_we);
         end
      end
   endtask

   // Triggers one DMA (called at a negedge) and checks it against the model.
   task automatic run_dma(input logic [7:0] page, input logic [7:0] start,
                          input bit retrig, input string name);
      int cyc;
      int first_rd;
      int n;
      bit exp_align;
      logic [15:0] exp_rd;
      logic [15:0] exp_wr;
      rd_q.delete();
      wr_q.delete();
      halt_cnt = 0;
      leak = 0;
      cpu_addr = REG;
      cpu_dout = page;
      oam_start = start;
      cpu_wr = 1'b1;
      @(posedge clk);
      #1;
      cpu_wr = 1'b0;
      cpu_dout = 8'($urandom);
      oam_start = 8'($urandom);
      cpu_addr = 16'($urandom);
      @(negedge clk);
      n_vec++;
      if ({cpu_rdy, dma_active, dma_rd, oam_we} !== 4'b0100) begin
         n_err++;
         $display("FAIL %s_halt_entry got rdy=%b act=%b rd=%b we=%b want 0 1 0 0",
                  name, cpu_rdy, dma_active, dma_rd, oam_we);
      end
      exp_align = ALIGN_EN && mpar;
      first_rd = -1;
      cyc = 0;
      while (cpu_rdy !== 1'b1 && cyc < 2000) begin
         if (first_rd < 0 && dma_rd === 1'b1) first_rd = cyc;
         if (retrig && cyc == 60) begin
            cpu_addr = REG;
            cpu_dout = ~page;
            cpu_wr = 1'b1;
         end else begin
            cpu_wr = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      cpu_wr = 1'b0;
      n_vec++;
      if (cyc >= 2000) begin
         n_err++;
         $display("FAIL %s_timeout cpu_rdy still %b after %0d cycles, want 1", name, cpu_rdy, cyc);
      end
      n_vec++;
      if (first_rd !== 1 + int'(exp_align)) begin
         n_err++;
         $display("FAIL %s_first_read got cycle %0d want %0d", name, first_rd, 1 + int'(exp_align));
      end
      n_vec++;
      if (halt_cnt !== 513 + int'(exp_align)) begin
         n_err++;
         $display("FAIL %s_halt_len got %0d want %0d", name, halt_cnt, 513 + int'(exp_align));
      end
      n_vec++;
      if (rd_q.size() !== 256 || wr_q.size() !== 256) begin
         n_err++;
         $display("FAIL %s_count got reads=%0d writes=%0d want 256 256", name, rd_q.size(), wr_q.size());
      end
      n = (rd_q.size() < wr_q.size()) ? rd_q.size() : wr_q.size();
      if (n > 256) n = 256;
      for (int k = 0; k < n; k++) begin
         exp_rd = {page, 8'(k)};
         exp_wr = {8'(start + 8'(k)), bus_fn(exp_rd)};
         n_vec++;
         if (rd_q[k] !== exp_rd || wr_q[k] !== exp_wr) begin
            n_err++;
            $display("FAIL %s_byte%0d got rd=%h wr(addr,data)=%h want rd=%h wr=%h",
                     name, k, rd_q[k], wr_q[k], exp_rd, exp_wr);
         end
      end
      n_vec++;
      if (leak !== 0 || dma_active !== 1'b0) begin
         n_err++;
         $display("FAIL %s_idle_outputs got leaks=%0d act=%b want 0 0", name, leak, dma_active);
      end
   endtask

   task automatic test_basic();
      bus_mode = 0;
      @(negedge clk);
      run_dma(8'h02, 8'h00, 1'b0, "page02");
   endtask

   task automatic test_wrap();
      logic [7:0] pg;
      bus_mode = 1;
      pg = 8'($urandom);
      run_dma(pg, 8'hF0, 1'b0, "wrap");
      n_vec++;
      if (wr_q.size() != 256 || wr_q[0][15:8] !== 8'hF0 || wr_q[16][15:8] !== 8'h00 ||
          wr_q[255][15:8] !== 8'hEF) begin
         n_err++;
         $display("FAIL wrap_points got first/16th/last addr %h %h %h want f0 00 ef",
                  wr_q[0][15:8], wr_q[16][15:8], wr_q[255][15:8]);
      end
   endtask

   task automatic test_align();
      for (int want = 0; want < 2; want++) begin
         int guard;
         guard = 0;
         // Parity during HALT is the inverse of its value at the trigger negedge.
         while (mpar !== ~1'(want) && guard < 4) begin
            @(negedge clk);
            guard++;
         end
         run_dma(8'($urandom), 8'($urandom), 1'b0, want ? "align_odd" : "align_even");
      end
   endtask

   task automatic test_retrigger();
      run_dma(8'h5C, 8'($urandom), 1'b1, "retrig");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++)
         run_dma(8'($urandom), 8'($urandom), 1'b0, "b2b");
   endtask

   task automatic test_reset_mid();
      int cyc;
      wr_q.delete();
      cpu_addr = REG;
      cpu_dout = 8'h37;
      oam_start = 8'h10;
      cpu_wr = 1'b1;
      @(posedge clk);
      #1;
      cpu_wr = 1'b0;
      cyc = 0;
      while (wr_q.size() < 100 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      n_vec++;
      if (cyc >= 1000) begin
         n_err++;
         $display("FAIL midreset_wait got %0d writes want 100", wr_q.size());
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({cpu_rdy, dma_active, dma_rd, oam_we, dma_addr, oam_addr, oam_din} !== {4'b1000, 32'h0}) begin
         n_err++;
         $display("FAIL midreset_async got rdy=%b act=%b rd=%b we=%b want 1 0 0 0",
                  cpu_rdy, dma_active, dma_rd, oam_we);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if (cpu_rdy !== 1'b1 || oam_we !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_hold%0d got rdy=%b we=%b want 1 0", i, cpu_rdy, oam_we);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_dma(8'($urandom), 8'($urandom), 1'b0, "restart");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_align();
      test_retrigger();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
